// File: rtl/tx_ds_pkg.sv
// Shared constants and helpers for the DS-link character transmitter.
package tx_ds_pkg;

    typedef enum logic [1:0] {
        FCT = 2'b00,
        EOP = 2'b01,
        EEP = 2'b10,
        ESC = 2'b11
    } ctrl_code_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } tx_state_e;

    localparam int unsigned NCHAR_LEN = 10;
    localparam int unsigned LCHAR_LEN = 4;

    // XOR of the payload bits that actually go on the line for this character.
    function automatic logic payload_parity(input logic [7:0] dat, input logic lchar);
        return lchar ? ^dat[1:0] : ^dat;
    endfunction

endpackage

// File: rtl/tx_ds_se.sv
// Bit-level DS line driver: d follows the bit, s toggles when d would not,
// so that d^s changes on every transmitted bit.
module tx_ds_se (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bit_i,
    input  logic bitValid_i,
    output logic d_o,
    output logic s_o
);

    logic d_q;
    logic s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
            s_q <= 1'b0;
        end else if (bitValid_i) begin
            d_q <= bit_i;
            if (bit_i == d_q) begin
                s_q <= ~s_q;
            end
        end
    end

    assign d_o = d_q;
    assign s_o = s_q;

endmodule

// File: rtl/tx_ds_encoder.sv
// DS-link character encoder: serialises N-chars and L-chars as P, F, payload
// (LSB first) with odd parity spanning the previous payload.
module tx_ds_encoder
    import tx_ds_pkg::*;
#(
    parameter int IDLE_HOLD = 1
) (
    input  logic       txClk,
    input  logic       txReset,
    input  logic [7:0] dat_i,
    input  logic       lchar_i,
    input  logic       stb_i,
    output logic       ack_o,
    output logic       d,
    output logic       s,
    output logic       busy_o
);

    if (IDLE_HOLD != 1) begin : g_idle_hold
        $error("tx_ds_encoder: IDLE_HOLD=0 is not implemented");
    end

    tx_state_e  state_q;
    logic [3:0] cnt_q;
    logic [8:0] sr_q;
    logic       par_q;

    logic       last_bit;
    logic       ack;
    logic       p_bit;
    logic [9:0] word;
    logic [3:0] load_cnt;
    logic       bit_valid;
    logic       bit_val;

    // ack is combinational: the first bit (P) must be registered onto d at the
    // same edge that accepts the character, giving one cycle of latency.
    always_comb begin
        last_bit  = (state_q == ST_SHIFT) && (cnt_q == '0);
        ack       = ~txReset & stb_i & ((state_q == ST_IDLE) | last_bit);
        p_bit     = 1'b1 ^ lchar_i ^ par_q;
        word      = lchar_i ? {6'b0, dat_i[1:0], lchar_i, p_bit}
                            : {dat_i, lchar_i, p_bit};
        load_cnt  = lchar_i ? 4'(LCHAR_LEN - 1) : 4'(NCHAR_LEN - 1);
        bit_valid = ack | ((state_q == ST_SHIFT) & (cnt_q != '0));
        bit_val   = ack ? word[0] : sr_q[0];
    end

    // cnt_q counts bits still held in sr_q; zero in SHIFT means d shows the last bit.
    always_ff @(posedge txClk) begin
        if (txReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
        end else if (ack) begin
            state_q <= ST_SHIFT;
            sr_q    <= word[9:1];
            cnt_q   <= load_cnt;
            par_q   <= payload_parity(dat_i, lchar_i);
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        sr_q  <= {1'b0, sr_q[8:1]};
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    tx_ds_se u_se (
        .clk_i      (txClk),
        .rst_i      (txReset),
        .bit_i      (bit_val),
        .bitValid_i (bit_valid),
        .d_o        (d),
        .s_o        (s)
    );

    assign ack_o  = ack;
    assign busy_o = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_tx_ds_encoder.sv
// Directed bench for tx_ds_encoder with a bench-side DS line decoder for a random stream.
module tb_tx_ds_encoder;
    import tx_ds_pkg::*;

    logic       txClk   = 1'b0;
    logic       txReset = 1'b1;
    logic [7:0] dat_i   = '0;
    logic       lchar_i = 1'b0;
    logic       stb_i   = 1'b0;
    logic       ack_o;
    logic       d;
    logic       s;
    logic       busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic rxq[$];
    logic prev_x;

    localparam int NCH = 24;
    logic [7:0] cdat [NCH];
    logic       clc  [NCH];

    int D41 [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int S41 [10] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    int DEOP[4]  = '{0, 1, 1, 0};
    int SEOP[4]  = '{1, 1, 0, 0};
    int DESC[4]  = '{0, 1, 1, 1};
    int SESC[4]  = '{1, 1, 0, 1};
    int DFCT[4]  = '{0, 1, 0, 0};
    int SFCT[4]  = '{1, 1, 1, 0};
    int DEEP[4]  = '{0, 1, 0, 1};
    int SEEP[4]  = '{1, 1, 1, 1};
    int DFF [6]  = '{0, 0, 1, 1, 1, 1};
    int D00 [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int S00 [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    tx_ds_encoder #(.IDLE_HOLD(1)) dut (
        .txClk   (txClk),
        .txReset (txReset),
        .dat_i   (dat_i),
        .lchar_i (lchar_i),
        .stb_i   (stb_i),
        .ack_o   (ack_o),
        .d       (d),
        .s       (s),
        .busy_o  (busy_o)
    );

    always #5 txClk = ~txClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge txClk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic stb, input logic lc, input logic [7:0] dt);
        txReset = rst;
        stb_i   = stb;
        lchar_i = lc;
        dat_i   = dt;
        #1;
    endtask

    task automatic line(input string tag, input int i, input int ed, input int es,
                        input logic eack);
        chk($sformatf("%s_d%0d", tag, i), d, ed);
        chk($sformatf("%s_s%0d", tag, i), s, es);
        chk($sformatf("%s_busy%0d", tag, i), busy_o, 1);
        chk($sformatf("%s_ack%0d", tag, i), ack_o, eack);
    endtask

    task automatic rx_step();
        if ((d ^ s) !== prev_x) begin
            rxq.push_back(d);
            prev_x = d ^ s;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with stb_i asserted to show reset priority
        drive(1, 1, 0, 8'h41);
        chk("rst_ack", ack_o, 0);
        tick();
        chk("rst_d", d, 0);
        chk("rst_s", s, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ack2", ack_o, 0);

        // Single N-char 0x41; source data changes right after acceptance
        drive(0, 1, 0, 8'h41);
        chk("t1_ack", ack_o, 1);
        chk("t1_busy_pre", busy_o, 0);
        tick();
        drive(0, 0, 1, 8'hAA);
        for (int i = 0; i < 10; i++) begin
            line("t1", i, D41[i], S41[i], 1'b0);
            tick();
        end
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_d", d, 0);
        chk("t1_idle_s", s, 0);
        tick();
        chk("t1_hold_d", d, 0);
        chk("t1_hold_s", s, 0);

        // 0x41 then EOP with stb_i held high throughout
        drive(0, 1, 0, 8'h41);
        chk("t2_ack", ack_o, 1);
        tick();
        drive(0, 1, 1, 8'h01);
        for (int i = 0; i < 10; i++) begin
            line("t2n", i, D41[i], S41[i], i == 9);
            tick();
        end
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            line("t2eop", i, DEOP[i], SEOP[i], 1'b0);
            tick();
        end
        chk("t2_idle_busy", busy_o, 0);

        // ESC then FCT after reset
        drive(1, 0, 0, 8'h00);
        tick();
        drive(0, 1, 1, 8'h03);
        chk("t3_ack", ack_o, 1);
        tick();
        drive(0, 1, 1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            line("t3esc", i, DESC[i], SESC[i], i == 3);
            tick();
        end
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            line("t3fct", i, DFCT[i], SFCT[i], 1'b0);
            tick();
        end
        chk("t3_idle_busy", busy_o, 0);

        // stb_i pulse at bit 3 is ignored; held stb_i from bit 6 is accepted on the last bit
        drive(0, 1, 0, 8'h41);
        chk("t4_ack", ack_o, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i >= 6) drive(0, 1, 1, 8'h02);
            else drive(0, 0, 0, 8'h00);
            line("t4n", i, D41[i], S41[i], i == 9);
            tick();
        end
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            line("t4eep", i, DEEP[i], SEEP[i], 1'b0);
            tick();
        end
        chk("t4_idle_busy", busy_o, 0);

        // Reset during bit 5 of 0xFF, then 0x00 restarts parity from zero
        drive(0, 1, 0, 8'hFF);
        chk("t5_ack", ack_o, 1);
        tick();
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t5ff_d%0d", i), d, DFF[i]);
            if (i == 5) begin
                drive(1, 1, 0, 8'h00);
                chk("t5_rst_ack", ack_o, 0);
            end else begin
                tick();
            end
        end
        tick();
        chk("t5_rst_d", d, 0);
        chk("t5_rst_s", s, 0);
        chk("t5_rst_busy", busy_o, 0);
        drive(0, 1, 0, 8'h00);
        chk("t5_ack00", ack_o, 1);
        tick();
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            line("t5z", i, D00[i], S00[i], 1'b0);
            tick();
        end
        chk("t5_idle_busy", busy_o, 0);

        // Random stream decoded from the line by the bench
        for (int k = 0; k < NCH; k++) begin
            cdat[k] = 8'($urandom);
            clc[k]  = ($urandom_range(0, 2) == 0);
        end
        begin
            int idx   = 0;
            int gap   = 0;
            int flush = 0;
            int pos   = 0;
            logic pp  = 1'b0;
            prev_x = d ^ s;
            for (int c = 0; c < 800 && flush < 14; c++) begin
                tick();
                rx_step();
                if (idx < NCH && gap == 0) begin
                    drive(0, 1, clc[idx], cdat[idx]);
                end else begin
                    drive(0, 0, 0, 8'h00);
                    if (gap > 0) gap--;
                end
                if (ack_o) begin
                    idx++;
                    gap = $urandom_range(0, 2);
                end
                if (idx == NCH) flush++;
            end
            chk("rx_acks", idx, NCH);
            for (int k = 0; k < NCH; k++) begin
                int         len;
                logic [7:0] pay;
                logic [7:0] epay;
                len  = clc[k] ? 2 : 8;
                epay = clc[k] ? {6'b0, cdat[k][1:0]} : cdat[k];
                chk($sformatf("rx_len%0d", k), (pos + 2 + len) <= rxq.size(), 1);
                if ((pos + 2 + len) > rxq.size()) break;
                pay = '0;
                for (int b = 0; b < len; b++) pay[b] = rxq[pos + 2 + b];
                chk($sformatf("rx_char%0d", k), {rxq[pos + 1], pay}, {clc[k], epay});
                chk($sformatf("rx_parity%0d", k), rxq[pos] ^ rxq[pos + 1] ^ pp, 1);
                pp  = ^pay;
                pos = pos + 2 + len;
            end
            chk("rx_bitcount", rxq.size(), pos);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
